// File: rtl/mux2to1_arbiter.sv
// Two-input round-robin stream arbiter with a single-entry registered output buffer.
// Drives the shared 2:1 datapath select and the valid/ready handshakes on all sides.
module mux2to1_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fixed_pri,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             r_last;
  logic             r_full;
  logic [WIDTH-1:0] r_out_data;

  logic             w_sel;
  logic             w_space;
  logic             w_accept;

  // Grant depends only on the valids, the mode and the last winner; data never feeds control.
  always_comb begin
    w_sel = ~r_last;
    unique case ({in1_valid, in0_valid})
      2'b01:   w_sel = 1'b0;
      2'b10:   w_sel = 1'b1;
      2'b11:   w_sel = fixed_pri ? 1'b0 : ~r_last;
      default: w_sel = ~r_last;
    endcase
  end

  assign w_space  = ~r_full | out_ready;
  assign w_accept = ~reset & w_space & (in0_valid | in1_valid);

  assign sel       = w_sel;
  assign in0_ready = w_accept & ~w_sel;
  assign in1_ready = w_accept & w_sel;
  assign out_data  = r_out_data;
  assign out_valid = r_full;

  // A drain and an accept in the same cycle simply refills the buffer, so there is no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full     <= 1'b0;
      r_out_data <= '0;
      r_last     <= 1'b1;
    end else if (w_accept) begin
      r_full     <= 1'b1;
      r_out_data <= w_sel ? in1_data : in0_data;
      r_last     <= w_sel;
    end else if (r_full && out_ready) begin
      r_full     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Directed bench for mux2to1_arbiter: stimulus pushes hand-computed words into a
// scoreboard queue; an independent monitor pops and compares on each output handshake.
module tb_mux2to1_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             fixed_pri;
  logic [WIDTH-1:0] in0_data, in1_data;
  logic             in0_valid, in1_valid;
  logic             in0_ready, in1_ready;
  logic             sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  int n_total = 0;
  int n_pass  = 0;
  logic [WIDTH-1:0] sb_q[$];

  always #5 clk = ~clk;

  mux2to1_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .fixed_pri (fixed_pri),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // One clock of stimulus. Readies/sel/out_valid are checked at the falling edge;
  // e_sel/e_ov < 0 skip that check. A granted word is pushed as the expected output.
  task automatic cyc(input logic rst, input logic fp,
                     input logic v0, input logic [WIDTH-1:0] d0,
                     input logic v1, input logic [WIDTH-1:0] d1,
                     input logic ordy, input logic e_r0, input logic e_r1,
                     input int e_sel, input int e_ov);
    reset = rst; fixed_pri = fp;
    in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1;
    out_ready = ordy;
    @(negedge clk);
    chk("in0_ready", {31'b0, in0_ready}, {31'b0, e_r0});
    chk("in1_ready", {31'b0, in1_ready}, {31'b0, e_r1});
    if (e_sel >= 0) chk("sel", {31'b0, sel}, WIDTH'(e_sel));
    if (e_ov >= 0)  chk("out_valid", {31'b0, out_valid}, WIDTH'(e_ov));
    if (e_r0) sb_q.push_back(d0);
    if (e_r1) sb_q.push_back(d1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: independent of stimulus, consumes the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (reset !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL out_unexpected: got 0x%0h expected no word at %0t", out_data, $time);
      end else begin
        chk("out_data", out_data, sb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with both valids high
    cyc(1, 0, 1, 32'hA0, 1, 32'hB1, 1, 0, 0, -1, -1);
    cyc(1, 0, 1, 32'hA0, 1, 32'hB1, 1, 0, 0, -1, -1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);

    // round-robin contention: in0 first, then strict alternation
    cyc(0, 0, 1, 32'hA0, 1, 32'hB1, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 32'hA0, 1, 32'hB1, 1, 0, 1, 1, 1);
    cyc(0, 0, 1, 32'hA0, 1, 32'hB1, 1, 1, 0, 0, 1);
    cyc(0, 0, 1, 32'hA0, 1, 32'hB1, 1, 0, 1, 1, 1);

    // fixed priority: in0 always; then back to round-robin, in1 next
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 32'hA0, 1, 32'hB1, 1, 1, 0, 0, 1);
    cyc(0, 0, 1, 32'hA0, 1, 32'hB1, 1, 0, 1, 1, 1);

    // backpressure: 0x55 from in1, then consumer stalls 3 cycles with in0 waiting
    cyc(0, 0, 0, 32'h0, 1, 32'h55, 1, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 32'h66, 0, 32'h0, 0, 0, 0, 0, 1);
      chk("bp_out_data", out_data, 32'h55);
      chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
    end
    cyc(0, 0, 1, 32'h66, 0, 32'h0, 1, 1, 0, 0, 1);

    // single requester burst on in1, then contention goes to in0
    for (int i = 1; i <= 4; i++)
      cyc(0, 0, 0, 32'h0, 1, WIDTH'(i), 1, 0, 1, 1, 1);
    cyc(0, 0, 1, 32'h77, 1, 32'h88, 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 1, 1);
    chk("idle_out_valid", {31'b0, out_valid}, 32'h0);

    // reset mid-burst: buffer full with 0x91 and stalled, then reset discards it
    cyc(0, 0, 1, 32'h90, 1, 32'h91, 0, 0, 1, 1, 0);
    void'(sb_q.pop_back());
    cyc(1, 0, 1, 32'h90, 1, 32'h91, 0, 0, 0, -1, 1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_out_data", out_data, 32'h0);
    cyc(0, 0, 1, 32'hA5, 1, 32'hB5, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 1, 1);
    cyc(0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 1, 0);

    chk("sb_empty", WIDTH'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux2to1_arbiter.md
# mux2to1_arbiter

Two-input round-robin stream arbiter that shares one datapath channel between two requesters. It generates the select for the shared 2:1 data mux, applies valid/ready handshakes on both inputs and the output, and registers the selected word in a single-entry output buffer. It sits in front of any ALU or PE operand port that two producers feed in the RipTide fabric.

## Interface
Parameters:
- WIDTH, 32, data word width.

Ports:
- clk, in, 1, sole clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-high.
- fixed_pri, in, 1, 0 = round-robin, 1 = fixed priority (in0 always wins); sampled every cycle.
- in0_data, in, WIDTH, requester 0 word.
- in0_valid, in, 1, requester 0 has a word.
- in0_ready, out, 1, requester 0 word is accepted this cycle.
- in1_data, in, WIDTH, requester 1 word.
- in1_valid, in, 1, requester 1 has a word.
- in1_ready, out, 1, requester 1 word is accepted this cycle.
- sel, out, 1, combinational mux select for the shared datapath (0 = in0, 1 = in1).
- out_data, out, WIDTH, registered output word.
- out_valid, out, 1, output buffer holds a word.
- out_ready, in, 1, consumer accepts out_data this cycle.

## Operation
- State: `last` (1 bit, the last granted input), `full` (drives out_valid), `out_data` register.
- `space` = !full | out_ready (buffer empty, or draining this cycle).
- Grant (combinational):
  - Only in0_valid: sel = 0.
  - Only in1_valid: sel = 1.
  - Both valid: if fixed_pri = 1, sel = 0; otherwise sel = !last.
  - Neither valid: sel = !last. No grant is issued.
- `accept` = space & (in0_valid | in1_valid).
- in0_ready = accept & !sel; in1_ready = accept & sel. At most one ready is high per cycle.
- in*_ready must not depend on the same input's valid except through the grant. A requester must not drop valid until it sees ready.
- On accept: out_data <= sel ? in1_data : in0_data; full <= 1; last <= sel.
- On a drain (full & out_ready) with no accept: full <= 0, and out_data holds its value.
- `last` updates only on accept. It updates in fixed_pri mode too, so round-robin resumes fairly after a mode switch.
- Reset values: full = 0 (out_valid = 0), out_data = 0, last = 1 (in0 wins the first contention), in0_ready = in1_ready = 0 while reset is high.

## Timing
- Latency: 1 cycle from input handshake to out_valid/out_data.
- Throughput: 1 word per cycle when out_ready stays high. Simultaneous drain and accept in the same cycle is required and yields no bubble.
- Backpressure: when full & !out_ready, both in*_ready = 0, and out_data/out_valid hold stable until the handshake.
- Under continuous contention in round-robin mode, grants strictly alternate 0,1,0,1...
- Reset mid-operation: the buffered word is discarded (out_valid = 0 on the cycle after reset is sampled high), `last` returns to 1, and no ready is asserted during reset.
- sel is purely combinational from the valids, fixed_pri and `last`. There is no combinational path from in*_data to any control output.

## Test plan
- Reset: hold reset for 2 cycles with both valids high and out_ready = 1. Required: out_valid = 0, out_data = 0, in0_ready = in1_ready = 0. Release reset: in0 is granted first (sel = 0).
- Contention, round-robin: in0_data = 0xA0 and in1_data = 0xB1 held valid, out_ready = 1, fixed_pri = 0. Required: out_data sequence 0xA0, 0xB1, 0xA0, 0xB1, with out_valid continuously high from cycle 1.
- Fixed priority: same stimulus with fixed_pri = 1. Required: only in0 is granted (out_data = 0xA0 every cycle) and in1_ready stays 0. Switch to fixed_pri = 0: the next grant goes to in1.
- Backpressure: one word 0x55 accepted from in1, then out_ready = 0 for 3 cycles while in0 is valid. Required: out_data = 0x55 and out_valid = 1 stable, in0_ready = 0 throughout. On the cycle out_ready = 1, in0 is accepted in the same cycle.
- Single requester: only in1 valid with a 4-word burst 1,2,3,4. Required: 4 consecutive grants to in1 and out_data = 1,2,3,4. The next contention then goes to in0.
- Reset mid-burst: assert reset while full = 1 and both inputs valid. Required: out_valid = 0 the next cycle, the held word is never presented, and the post-reset first grant goes to in0.
